pmcc_matrix_sequencer: RTL and testbench

- Parametrised successor to the PMC coprocessor matrix control register.
- Supports direct single-word writes of the pixel-matrix control word, as the current block does.
- Adds a FIFO of timed control words (word + hold count) that plays back autonomously after a start command. The coprocessor can queue a shift/strobe/gate pattern and let hardware generate cycle-exact waveforms.
- Sits between the PMC coprocessor and the pixel-matrix control pins.

---
 rtl/pmcc_matrix_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_pmcc_matrix_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmcc_matrix_sequencer.sv
// ---------------------------------------------------------------------------
// pmcc_matrix_sequencer
//
// Drives the pixel-matrix control pins from one control register. The PMC
// coprocessor can load that register in two ways:
//   * a direct single-word write (store / store_ctrl), or
//   * a FIFO of timed words {ctrl, hold}. After start, the FIFO plays back
//     on its own and gives cycle-exact waveforms. An entry with hold h stays
//     on the pins for h+1 cycles.
//
// Ports
//   clk, rst_n       clock and asynchronous active-low reset
//   clear            synchronous soft reset, same effect as rst_n
//   store/store_ctrl direct write, accepted only while idle
//   push_*           FIFO write channel (push_ready = FIFO not full)
//   start/abort      begin playback / stop playback and flush the FIFO
//   busy/done/err    status: playing back / end-of-playback pulse /
//                    sticky "store or start rejected"
//   level            FIFO occupancy
//   res..clkSh       fields of the control register, all driven by flops
// ---------------------------------------------------------------------------
module pmcc_matrix_sequencer #(
    parameter int RES_WIDTH  = 10,
    parameter int DEPTH      = 8,
    parameter int HOLD_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     store,
    input  logic [RES_WIDTH+5:0]     store_ctrl,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [RES_WIDTH+5:0]     push_ctrl,
    input  logic [HOLD_WIDTH-1:0]    push_hold,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [$clog2(DEPTH):0]   level,
    output logic [RES_WIDTH-1:0]     res,
    output logic                     write_cfg,
    output logic                     strobe,
    output logic                     gate,
    output logic                     shB,
    output logic                     shA,
    output logic                     clkSh
);

    localparam int CW = RES_WIDTH + 6;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = CW + HOLD_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         ctrl, ctrl_next;
    logic [HOLD_WIDTH-1:0] cnt, cnt_next;
    logic [PW-1:0]         wr_ptr, wr_ptr_next;
    logic [PW-1:0]         rd_ptr, rd_ptr_next;
    logic [LW-1:0]         level_next;
    logic                  err_next;
    logic                  done_next;
    logic                  push_en;
    logic                  pop;

    logic [EW-1:0]         mem [DEPTH];
    logic [CW-1:0]         head_ctrl;
    logic [HOLD_WIDTH-1:0] head_hold;

    assign head_ctrl  = mem[rd_ptr][EW-1:HOLD_WIDTH];
    assign head_hold  = mem[rd_ptr][HOLD_WIDTH-1:0];
    assign push_ready = (level != LW'(DEPTH));

    // A push on a full FIFO is dropped without an error. push_ready already
    // tells the writer the FIFO is full. A push in an abort cycle is
    // discarded together with the flush.
    assign push_en = push_valid && push_ready && !abort;

    // Next-state logic. abort has priority over everything. A pop only looks
    // at the level before the edge, so a word pushed into an empty FIFO in
    // the last cycle of playback does not extend that playback.
    always_comb begin
        state_next = state;
        ctrl_next  = ctrl;
        cnt_next   = cnt;
        err_next   = err;
        done_next  = 1'b0;
        pop        = 1'b0;
        if (abort) begin
            state_next = IDLE;
            ctrl_next  = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && level != '0) begin
                        pop        = 1'b1;
                        ctrl_next  = head_ctrl;
                        cnt_next   = head_hold;
                        state_next = RUN;
                    end else begin
                        if (start) begin
                            err_next = 1'b1;
                        end
                        if (store) begin
                            ctrl_next = store_ctrl;
                        end
                    end
                end
                RUN: begin
                    if (store) begin
                        err_next = 1'b1;
                    end
                    if (cnt != '0) begin
                        cnt_next = cnt - HOLD_WIDTH'(1);
                    end else if (level != '0) begin
                        pop       = 1'b1;
                        ctrl_next = head_ctrl;
                        cnt_next  = head_hold;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FIFO bookkeeping. The pointers wrap by themselves because DEPTH is a
    // power of two.
    always_comb begin
        wr_ptr_next = wr_ptr;
        rd_ptr_next = rd_ptr;
        level_next  = level;
        if (abort) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            level_next  = '0;
        end else begin
            if (push_en) begin
                wr_ptr_next = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr + PW'(1);
            end
            level_next = level + LW'(push_en) - LW'(pop);
        end
    end

    // State register. clear has the same effect as rst_n but acts at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ctrl   <= '0;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else if (clear) begin
            state  <= IDLE;
            ctrl   <= '0;
            cnt    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            ctrl   <= ctrl_next;
            cnt    <= cnt_next;
            wr_ptr <= wr_ptr_next;
            rd_ptr <= rd_ptr_next;
            level  <= level_next;
            err    <= err_next;
            done   <= done_next;
        end
    end

    // The storage array has no reset. The pointers and level decide which
    // entries are valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr] <= {push_ctrl, push_hold};
        end
    end

    assign busy      = (state == RUN);
    assign res       = ctrl[CW-1:6];
    assign write_cfg = ctrl[5];
    assign strobe    = ctrl[4];
    assign gate      = ctrl[3];
    assign shB       = ctrl[2];
    assign shA       = ctrl[1];
    assign clkSh     = ctrl[0];

endmodule

// File: tb/tb_pmcc_matrix_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pmcc_matrix_sequencer
//
// Self-checking bench for pmcc_matrix_sequencer with default parameters
// (CW = 16, DEPTH = 8, HOLD = 8 bits). A vector table covers direct writes
// and the basic three-word waveform. Expected playback words are queued when
// entries are pushed and are popped cycle by cycle as the DUT plays them out.
// Inputs change 1 time unit after the rising edge, and outputs are sampled
// at that same point.
// ---------------------------------------------------------------------------
module tb_pmcc_matrix_sequencer;

    localparam int RES_WIDTH  = 10;
    localparam int DEPTH      = 8;
    localparam int HOLD_WIDTH = 8;
    localparam int CW         = RES_WIDTH + 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    clear;
    logic                    store;
    logic [CW-1:0]           store_ctrl;
    logic                    push_valid;
    logic                    push_ready;
    logic [CW-1:0]           push_ctrl;
    logic [HOLD_WIDTH-1:0]   push_hold;
    logic                    start;
    logic                    abort;
    logic                    busy;
    logic                    done;
    logic                    err;
    logic [$clog2(DEPTH):0]  level;
    logic [RES_WIDTH-1:0]    res;
    logic                    write_cfg;
    logic                    strobe;
    logic                    gate;
    logic                    shB;
    logic                    shA;
    logic                    clkSh;
    logic [CW-1:0]           ctrl_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [CW-1:0] exp_q[$];

    typedef struct {
        logic          store;
        logic [CW-1:0] store_ctrl;
        logic          push_valid;
        logic [CW-1:0] push_ctrl;
        logic [7:0]    push_hold;
        logic          start;
        logic [CW-1:0] exp_ctrl;
        logic          exp_busy;
        logic          exp_done;
        logic          exp_err;
        int            exp_level;
        logic          exp_ready;
    } vec_t;

    vec_t vecs[12];

    pmcc_matrix_sequencer #(
        .RES_WIDTH (RES_WIDTH),
        .DEPTH     (DEPTH),
        .HOLD_WIDTH(HOLD_WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .store     (store),
        .store_ctrl(store_ctrl),
        .push_valid(push_valid),
        .push_ready(push_ready),
        .push_ctrl (push_ctrl),
        .push_hold (push_hold),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .level     (level),
        .res       (res),
        .write_cfg (write_cfg),
        .strobe    (strobe),
        .gate      (gate),
        .shB       (shB),
        .shA       (shA),
        .clkSh     (clkSh)
    );

    always #5 clk = ~clk;

    // Rebuild the control word from the individual pins so that a swapped
    // field is caught.
    assign ctrl_out = {res, write_cfg, strobe, gate, shB, shA, clkSh};

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Advance one clock edge, then drop all single-cycle request inputs.
    task automatic step();
        @(posedge clk);
        #1;
        store      = 1'b0;
        push_valid = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        store      = v.store;
        store_ctrl = v.store_ctrl;
        push_valid = v.push_valid;
        push_ctrl  = v.push_ctrl;
        push_hold  = v.push_hold;
        start      = v.start;
        step();
        check_output($sformatf("vec%0d ctrl", idx), 32'(ctrl_out), 32'(v.exp_ctrl));
        check_output($sformatf("vec%0d busy", idx), 32'(busy), 32'(v.exp_busy));
        check_output($sformatf("vec%0d done", idx), 32'(done), 32'(v.exp_done));
        check_output($sformatf("vec%0d err", idx), 32'(err), 32'(v.exp_err));
        check_output($sformatf("vec%0d level", idx), 32'(level), 32'(v.exp_level));
        check_output($sformatf("vec%0d ready", idx), 32'(push_ready), 32'(v.exp_ready));
    endtask

    // Push one entry and queue the word it must show during playback,
    // once per cycle it is held.
    task automatic push_entry(input logic [CW-1:0] c, input logic [7:0] h);
        push_valid = 1'b1;
        push_ctrl  = c;
        push_hold  = h;
        step();
        for (int k = 0; k <= int'(h); k++) exp_q.push_back(c);
    endtask

    // Start playback and compare each cycle against the queue. The loop is
    // bounded by the queue length. An optional extra entry is pushed
    // inject_at cycles after start; its expected words must already be queued.
    task automatic play_back(input string tag, input int inject_at,
                             input logic [CW-1:0] inj_ctrl, input logic [7:0] inj_hold);
        logic [CW-1:0] last;
        logic [CW-1:0] e;
        int n;
        n     = 0;
        last  = '0;
        start = 1'b1;
        while (exp_q.size() != 0) begin
            if (n == inject_at) begin
                push_valid = 1'b1;
                push_ctrl  = inj_ctrl;
                push_hold  = inj_hold;
            end
            step();
            n++;
            e    = exp_q.pop_front();
            last = e;
            check_output($sformatf("%s ctrl@%0d", tag, n), 32'(ctrl_out), 32'(e));
            check_output($sformatf("%s busy@%0d", tag, n), 32'(busy), 32'd1);
            check_output($sformatf("%s done early@%0d", tag, n), 32'(done), 32'd0);
        end
        step();
        check_output({tag, " done"}, 32'(done), 32'd1);
        check_output({tag, " busy end"}, 32'(busy), 32'd0);
        check_output({tag, " ctrl held"}, 32'(ctrl_out), 32'(last));
        step();
        check_output({tag, " done drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [CW-1:0] c;
        logic [7:0]    h;

        // Store 0x0015, push three timed words, then play them back.
        // ctrl outputs / busy / done / err / level / ready are checked after each edge.
        vecs[0]  = '{1'b1, 16'h0015, 1'b0, 16'h0000, 8'd0, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 0, 1'b1};
        vecs[1]  = '{1'b0, 16'h0000, 1'b1, 16'h0002, 8'd2, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 1, 1'b1};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 16'h0004, 8'd0, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 2, 1'b1};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 16'h0001, 8'd1, 1'b0, 16'h0015, 1'b0, 1'b0, 1'b0, 3, 1'b1};
        vecs[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 2, 1'b1};
        vecs[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 2, 1'b1};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 2, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b0, 16'h0004, 1'b1, 1'b0, 1'b0, 1, 1'b1};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 0, 1'b1};
        vecs[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 0, 1'b1};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 0, 1'b1};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0, 0, 1'b1};

        rst_n      = 1'b0;
        clear      = 1'b0;
        store      = 1'b0;
        store_ctrl = '0;
        push_valid = 1'b0;
        push_ctrl  = '0;
        push_hold  = '0;
        start      = 1'b0;
        abort      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_output("reset ctrl", 32'(ctrl_out), 32'd0);
        check_output("reset ready", 32'(push_ready), 32'd1);
        check_output("reset level", 32'(level), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        check_output("reset err", 32'(err), 32'd0);

        for (int i = 0; i < 12; i++) apply_stimulus(vecs[i], i);

        // Fill the FIFO. The write pointer crosses the wrap point here.
        for (int i = 0; i < DEPTH; i++) begin
            c = 16'($urandom);
            h = 8'($urandom_range(0, 3));
            push_entry(c, h);
            check_output($sformatf("fill level %0d", i), 32'(level), 32'(i + 1));
        end
        check_output("full ready", 32'(push_ready), 32'd0);
        push_valid = 1'b1;
        push_ctrl  = 16'hDEAD;
        push_hold  = 8'd0;
        step();
        check_output("drop level", 32'(level), 32'(DEPTH));
        check_output("drop err", 32'(err), 32'd0);
        play_back("full", -1, '0, '0);

        for (int i = 0; i < 3; i++) push_entry(16'h0100 << i, 8'(i));
        play_back("wrap", -1, '0, '0);

        // A word pushed while the first one is still holding must follow it
        // with no gap.
        push_entry(16'h0A0A, 8'd3);
        for (int k = 0; k < 2; k++) exp_q.push_back(16'h0B0B);
        play_back("seamless", 1, 16'h0B0B, 8'd1);

        // Rejected store during playback, clear, then start with an empty FIFO.
        exp_q.delete();
        push_entry(16'h0033, 8'd4);
        exp_q.delete();
        start = 1'b1;
        step();
        check_output("err run busy", 32'(busy), 32'd1);
        store      = 1'b1;
        store_ctrl = 16'hFFFF;
        step();
        check_output("store in run ctrl", 32'(ctrl_out), 32'h0033);
        check_output("store in run err", 32'(err), 32'd1);
        clear = 1'b1;
        step();
        check_output("clear err", 32'(err), 32'd0);
        check_output("clear ctrl", 32'(ctrl_out), 32'd0);
        check_output("clear busy", 32'(busy), 32'd0);
        check_output("clear done", 32'(done), 32'd0);
        start = 1'b1;
        step();
        check_output("empty start err", 32'(err), 32'd1);
        check_output("empty start busy", 32'(busy), 32'd0);
        clear = 1'b1;
        step();
        check_output("clear2 err", 32'(err), 32'd0);

        // Abort during the second of four entries.
        for (int i = 1; i <= 4; i++) push_entry(16'(i * 16'h0101), 8'd2);
        exp_q.delete();
        start = 1'b1;
        step();
        repeat (3) step();
        check_output("abort pre ctrl", 32'(ctrl_out), 32'h0202);
        abort      = 1'b1;
        push_valid = 1'b1;
        push_ctrl  = 16'h7777;
        push_hold  = 8'd0;
        step();
        check_output("abort ctrl", 32'(ctrl_out), 32'd0);
        check_output("abort level", 32'(level), 32'd0);
        check_output("abort busy", 32'(busy), 32'd0);
        check_output("abort done", 32'(done), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_output($sformatf("abort no done %0d", k), 32'(done), 32'd0);
        end

        // Asynchronous reset in the middle of playback.
        push_entry(16'h0AAA, 8'd5);
        exp_q.delete();
        start = 1'b1;
        step();
        step();
        check_output("rst pre busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_output("rst ctrl", 32'(ctrl_out), 32'd0);
        check_output("rst busy", 32'(busy), 32'd0);
        check_output("rst level", 32'(level), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_output("rst ready", 32'(push_ready), 32'd1);
        check_output("rst done", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
